display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexing scheduler that shares the single hex-to-seven-segment decoder among the four digits of the board display. It holds a double-buffered 16-bit display value and scans digits 0..3 in order. For each digit it drives the nibble to the shared decoder and asserts one active-low anode, and it inserts a blanking gap between digits to prevent ghosting. It sits between the counter/debouncer logic, which loads new values, and the decoder/anode pins.

## Interface
- TICKS_PER_DIGIT, default 100000: clock cycles each digit is lit (1 ms at 100 MHz); must be ≥1.
- BLANK_TICKS, default 1000: clock cycles all anodes are off before each digit; must be ≥1.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- value_in  input  16  display value; nibble i goes to digit i, with digit 0 rightmost.
- dp_in  input  4  decimal-point request per digit, active-high; captured together with value_in.
- load  input  1  one-cycle request to capture value_in/dp_in into the pending buffer.
- load_ack  output  1  one-cycle pulse confirming capture.
- hex_out  output  4  nibble to the shared decoder's hex input.
- an  output  4  digit anodes, active-low.
- dp_n  output  1  decimal-point segment, active-low.
- frame_start  output  1  one-cycle pulse when a new frame begins (digit 0 blanking entered).

## Operation
- **Buffers**
  - pending: 16-bit value + 4-bit dp + pending_valid flag.
  - shadow: 16-bit value + 4-bit dp; this is the only buffer ever displayed.
- **Load handshake**
  - load=1 in cycle N → pending captures value_in/dp_in and pending_valid=1 at edge N.
  - load_ack=1 during cycle N+1 only.
  - Back-to-back loads are allowed; the last one wins.
- **Commit**
  - At the end of digit 3's DRIVE slot: if pending_valid, then shadow←pending and pending_valid←0.
  - Commit never happens mid-frame, so no tearing.
- **State machine** (states BLANK, DRIVE; 2-bit digit index d; tick counter)
  - BLANK: an=1111, dp_n=1, hex_out=shadow nibble d. Lasts BLANK_TICKS cycles, then → DRIVE.
  - DRIVE: an has bit d low and all other bits high. dp_n=~dp[d]. Lasts TICKS_PER_DIGIT cycles, then d←d+1 (3 wraps to 0) → BLANK.
  - Counter width is $clog2(max(TICKS_PER_DIGIT, BLANK_TICKS)). It clears on each state change.
- **Simultaneous load and commit in the same cycle**
  - Commit takes the old pending contents.
  - The new load lands in pending, and pending_valid stays 1, so it commits next frame.
- **Reset** (synchronous; at any point, including mid-slot)
  - State=BLANK, d=0, counter=0, shadow=0, dp=0, pending=0, pending_valid=0.
  - Outputs: an=1111, hex_out=0, dp_n=1, load_ack=0, frame_start=0.
  - A load asserted during reset is ignored and gets no ack.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Slot lengths are exact:
  - BLANK: an=1111 for exactly BLANK_TICKS cycles.
  - DRIVE: an low for exactly TICKS_PER_DIGIT cycles.
  - Frame period is 4×(BLANK_TICKS+TICKS_PER_DIGIT) cycles.
- After reset deasserts (first cycle with reset=0 is cycle 0): an=1110 is first seen in cycle BLANK_TICKS.
- hex_out is valid from the start of BLANK, a full blank slot before the anode turns on, so decoder settling is hidden.
- frame_start:
  - Asserted during the first BLANK cycle of digit 0, in the same cycle the newly committed shadow is first visible on hex_out.
  - Not asserted on the first frame after reset.
- Worst-case load-to-display latency: one frame + BLANK_TICKS + 2 cycles.

## Configuration
- **LEADING_ZERO_BLANK_EN defined:** during DRIVE, digit d>0 keeps its anode high (stays dark) when shadow nibbles d..3 are all zero.
  - Digit 0 is always lit.
  - dp_n is still driven from dp[d] for dark digits, but it has no visible effect.
  - Slot timing is unchanged.
- **Undefined:** all four digits are lit every frame, zeros included.

## Test plan
Bench parameters for all scenarios: TICKS_PER_DIGIT=4, BLANK_TICKS=2 (frame = 24 cycles).
- **Reset and scan:** release reset and run 48 cycles.
  - an sequence per frame: 1111×2, 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4.
  - hex_out=0 throughout; dp_n=1.
- **Load and commit:** load value_in=16'h1A2F, dp_in=4'b0100 at cycle 5.
  - load_ack pulses at cycle 6.
  - hex_out stays 0 until frame_start at cycle 24.
  - Then hex_out=F,2,A,1 across the slots; dp_n=0 only during digit 2 DRIVE.
- **Last wins and simultaneous commit:**
  - Loads 16'h1111 (cycle 3) and 16'h2222 (cycle 10) → frame 2 shows 2222.
  - A load of 16'h3333 in the final DRIVE cycle of frame 2 → frame 3 shows 2222 and frame 4 shows 3333.
- **Mid-operation reset:** assert reset during digit 2 DRIVE with shadow=16'h1234.
  - Next cycle: an=1111, hex_out=0, load_ack=0.
  - After release, the scan restarts at digit 0 showing 0000.
- **Leading-zero blank:** value 16'h0050.
  - With LEADING_ZERO_BLANK_EN: digits 2 and 3 keep an=1111 during their DRIVE slots; digits 0 and 1 light.
  - Without the macro: all four digits light.

Source files
------------

// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if: load-side bus of the display scan controller.
// value_in/dp_in/load from the producer, load_ack back from the controller.
interface display_scan_controller_if;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        load_ack;

    modport master (
        output value_in,
        output dp_in,
        output load,
        input  load_ack
    );

    modport slave (
        input  value_in,
        input  dp_in,
        input  load,
        output load_ack
    );
endinterface

// File: rtl/display_scan_controller.sv
// display_scan_controller: double-buffered 4-digit scan of a shared hex decoder.
// Ports: clk, reset (sync, high), bus (slave: value_in, dp_in, load, load_ack),
//        hex_out, an (active-low), dp_n (active-low), frame_start.
// Option: LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module display_scan_controller #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic                             clk,
    input  logic                             reset,
    display_scan_controller_if.slave         bus,
    output logic [3:0]                       hex_out,
    output logic [3:0]                       an,
    output logic                             dp_n,
    output logic                             frame_start
);

    localparam int MAXT = (TICKS_PER_DIGIT > BLANK_TICKS) ?
                          TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [CW-1:0] DRIVE_LAST = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [1:0]    d, d_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   shadow, shadow_n;
    logic [3:0]    sdp, sdp_n;
    logic [15:0]   pend, pend_n;
    logic [3:0]    pdp, pdp_n;
    logic          pv, pv_n;
    logic          ack_q;
    logic          lit;
    logic [3:0]    hex_n, an_n;
    logic          dpn_n, fs_n;

    assign bus.load_ack = ack_q;

    // Outputs are decoded from the next-state values and registered, so
    // they line up with the state they describe in the same cycle.
    always_comb begin
        state_n  = state;
        d_n      = d;
        cnt_n    = cnt + 1'b1;
        shadow_n = shadow;
        sdp_n    = sdp;
        pend_n   = pend;
        pdp_n    = pdp;
        pv_n     = pv;
        fs_n     = 1'b0;
        unique case (state)
            S_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = S_DRIVE;
                    cnt_n   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_n = S_BLANK;
                    cnt_n   = '0;
                    d_n     = d + 2'd1;
                    // End of digit 3: frame boundary, the only commit point.
                    if (d == 2'd3) begin
                        fs_n = 1'b1;
                        if (pv) begin
                            shadow_n = pend;
                            sdp_n    = pdp;
                            pv_n     = 1'b0;
                        end
                    end
                end
            end
            default: state_n = S_BLANK;
        endcase
        // A load in the commit cycle lands after the commit read old pending.
        if (bus.load) begin
            pend_n = bus.value_in;
            pdp_n  = bus.dp_in;
            pv_n   = 1'b1;
        end

`ifdef LEADING_ZERO_BLANK_EN
        lit = (d_n == 2'd0) || ((shadow_n >> {d_n, 2'b00}) != 16'h0);
`else
        lit = 1'b1;
`endif

        hex_n = shadow_n[{d_n, 2'b00} +: 4];
        an_n  = 4'b1111;
        if (state_n == S_DRIVE && lit)
            an_n[d_n] = 1'b0;
        dpn_n = (state_n == S_DRIVE) ? ~sdp_n[d_n] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_BLANK;
            d           <= 2'd0;
            cnt         <= '0;
            shadow      <= 16'h0;
            sdp         <= 4'h0;
            pend        <= 16'h0;
            pdp         <= 4'h0;
            pv          <= 1'b0;
            ack_q       <= 1'b0;
            hex_out     <= 4'h0;
            an          <= 4'b1111;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            d           <= d_n;
            cnt         <= cnt_n;
            shadow      <= shadow_n;
            sdp         <= sdp_n;
            pend        <= pend_n;
            pdp         <= pdp_n;
            pv          <= pv_n;
            ack_q       <= bus.load;
            hex_out     <= hex_n;
            an          <= an_n;
            dp_n        <= dpn_n;
            frame_start <= fs_n;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed bench, TICKS_PER_DIGIT=4, BLANK_TICKS=2.
// Cycle 0 is the first cycle with reset low; a frame is 24 cycles.
module tb_display_scan_controller;

    localparam int T = 4;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] hex_out;
    logic [3:0] an;
    logic       dp_n;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_scan_controller_if bus();

    display_scan_controller #(
        .TICKS_PER_DIGIT(T),
        .BLANK_TICKS    (B)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .hex_out    (hex_out),
        .an         (an),
        .dp_n       (dp_n),
        .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int slot(input int c);
        return (c % 24) / 6;
    endfunction

    function automatic bit in_drive(input int c);
        return ((c % 24) % 6) >= 2;
    endfunction

    function automatic logic [3:0] an_all(input int c);
        logic [3:0] a;
        a = 4'b1111;
        if (in_drive(c))
            a[slot(c)] = 1'b0;
        return a;
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int i);
        return v[i*4 +: 4];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.value_in = 16'h0;
        bus.dp_in    = 4'h0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic set_load(input logic [15:0] v, input logic [3:0] p);
        bus.load     = 1'b1;
        bus.value_in = v;
        bus.dp_in    = p;
    endtask

    initial begin
        logic [15:0] v;
        logic [3:0]  ea;

        // Reset state, with a load held during reset (must not ack).
        reset = 1'b1;
        set_load(16'hBEEF, 4'hF);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_an", an, 4'b1111);
        chk("rst_hex", hex_out, 4'h0);
        chk("rst_dpn", dp_n, 1'b1);
        chk("rst_ack", bus.load_ack, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        tick();

        // Scan after reset: two frames of zeros.
        do_reset();
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            chk("scan_an", an, an_all(c));
            chk("scan_hex", hex_out, 4'h0);
            chk("scan_dpn", dp_n, 1'b1);
            chk("scan_fs", frame_start, c == 24);
            tick();
        end

        // Load and commit at the next frame boundary.
        do_reset();
        for (int c = 0; c < 48; c++) begin
            if (c == 5) set_load(16'h1A2F, 4'b0100);
            @(negedge clk);
            v = (c >= 24) ? 16'h1A2F : 16'h0;
            chk("ld_ack", bus.load_ack, c == 6);
            chk("ld_hex", hex_out, nib(v, slot(c)));
            chk("ld_dpn", dp_n, !(c >= 24 && in_drive(c) && slot(c) == 2));
            chk("ld_fs", frame_start, c == 24);
            tick();
            bus.load = 1'b0;
        end

        // Last load wins; load at frame end; load in a commit cycle.
        do_reset();
        for (int c = 0; c < 120; c++) begin
            if (c == 3)  set_load(16'h1111, 4'h0);
            if (c == 10) set_load(16'h2222, 4'h0);
            if (c == 47) set_load(16'h3333, 4'h0);
            if (c == 71) set_load(16'h4444, 4'h0);
            @(negedge clk);
            if (c < 24)      v = 16'h0000;
            else if (c < 72) v = 16'h2222;
            else if (c < 96) v = 16'h3333;
            else             v = 16'h4444;
            chk("lw_hex", hex_out, nib(v, slot(c)));
            chk("lw_ack", bus.load_ack,
                c == 4 || c == 11 || c == 48 || c == 72);
            tick();
            bus.load = 1'b0;
        end

        // Reset in digit 2 DRIVE with 1234 on display.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            if (c == 0) set_load(16'h1234, 4'h0);
            if (c == 39) begin
                reset = 1'b1;
                set_load(16'hFFFF, 4'hF);
            end
            @(negedge clk);
            if (c == 38) begin
                chk("mr_pre_an", an, 4'b1011);
                chk("mr_pre_hex", hex_out, 4'h2);
            end
            tick();
            if (c == 0) bus.load = 1'b0;
        end
        bus.load = 1'b0;
        reset    = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            chk("mr_an", an, an_all(c));
            chk("mr_hex", hex_out, 4'h0);
            if (c == 0) chk("mr_ack", bus.load_ack, 1'b0);
            tick();
        end

        // Leading-zero blanking on 0050.
        do_reset();
        for (int c = 0; c < 48; c++) begin
            if (c == 0) set_load(16'h0050, 4'h0);
            @(negedge clk);
            if (c >= 24) begin
                ea = an_all(c);
`ifdef LEADING_ZERO_BLANK_EN
                if (slot(c) >= 2) ea = 4'b1111;
`endif
                chk("lz_an", an, ea);
                chk("lz_hex", hex_out, nib(16'h0050, slot(c)));
            end
            tick();
            bus.load = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
